// File: rtl/control_pkg.sv
// Shared opcode constants, state encoding and control-word layout for the
// multicycle RV32I sequencing controller.
package control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_R   = 4'd2,
    S_EX_I   = 4'd3,
    S_WB     = 4'd4,
    S_ADDR   = 4'd5,
    S_LD_MEM = 4'd6,
    S_LD_WB  = 4'd7,
    S_ST_MEM = 4'd8,
    S_BR     = 4'd9,
    S_BR_NT  = 4'd10,
    S_JAL    = 4'd11,
    S_JALR   = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_BRANCH = 2'd1,
    ALU_FUNCT  = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'd0,
    SRCB_FOUR = 2'd1,
    SRCB_IMM  = 2'd2
  } alu_src_b_e;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       aluout_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       mem_to_reg;
    logic       pc_source;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    logic       illegal_op;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Ungated control word for the current phase; only ID looks at the opcode.
// Handshake, branch and reset qualification are applied by the parent.
module ctrl_decode
  import control_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] opcode_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o           = '0;
    ctrl_o.alu_src_b = SRCB_REG;
    ctrl_o.alu_op    = ALU_ADD;
    case (state_i)
      S_IF: begin
        ctrl_o.mem_read     = 1'b1;
        ctrl_o.ir_write     = 1'b1;
        ctrl_o.aluout_write = 1'b1;
        ctrl_o.alu_src_a    = 1'b1;
        ctrl_o.alu_src_b    = SRCB_FOUR;
      end
      S_ID: begin
        case (opcode_i)
          OP_BRANCH: begin
            ctrl_o.aluout_write = 1'b1;
            ctrl_o.alu_src_a    = 1'b1;
            ctrl_o.alu_src_b    = SRCB_IMM;
          end
          // ALUOut must keep PC+4 from IF for the jump link value
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR: ;
          default: begin
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.alu_src_a  = 1'b1;
            ctrl_o.alu_src_b  = SRCB_FOUR;
            ctrl_o.illegal_op = (opcode_i != OP_ECALL);
          end
        endcase
      end
      S_EX_R: begin
        ctrl_o.aluout_write = 1'b1;
        ctrl_o.alu_op       = ALU_FUNCT;
      end
      S_EX_I: begin
        ctrl_o.aluout_write = 1'b1;
        ctrl_o.alu_src_b    = SRCB_IMM;
        ctrl_o.alu_op       = ALU_FUNCT;
      end
      S_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
      end
      S_ADDR: begin
        ctrl_o.aluout_write = 1'b1;
        ctrl_o.alu_src_b    = SRCB_IMM;
      end
      S_LD_MEM: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_LD_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_FOUR;
      end
      S_ST_MEM: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
      end
      S_BR: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = 1'b1;
        ctrl_o.alu_op    = ALU_BRANCH;
      end
      S_BR_NT: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
      end
      S_JAL: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_JALR: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencer: phase state register, handshake/branch/halt
// gating of the decoded control word, and the retired-instruction counter.
module multicycle_control_fsm
  import control_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             ir_write,
  output logic             aluout_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             mem_to_reg,
  output logic             pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  ctrl_word_t       dec_ctrl, ctrl;
  logic             mem_rdy;

  assign mem_rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .ctrl_o   (dec_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:     if (mem_rdy) state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_R:               state_d = S_EX_R;
          OP_I:               state_d = S_EX_I;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH:          state_d = S_BR;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_ECALL:           state_d = halt_req ? S_HALT : S_IF;
          default:            state_d = S_IF;
        endcase
      end
      S_EX_R, S_EX_I:       state_d = S_WB;
      S_ADDR:               state_d = (opcode == OP_LOAD) ? S_LD_MEM : S_ST_MEM;
      S_LD_MEM: if (mem_rdy) state_d = S_LD_WB;
      S_ST_MEM: if (mem_rdy) state_d = S_IF;
      S_BR:                 state_d = bcond ? S_IF : S_BR_NT;
      S_HALT:               state_d = S_HALT;
      default:              state_d = S_IF;
    endcase
  end

  // Every surviving pc_write closes an instruction, so it doubles as retire
  always_comb begin
    ctrl = dec_ctrl;
    if (state_q == S_IF && !mem_rdy) begin
      ctrl.ir_write     = 1'b0;
      ctrl.aluout_write = 1'b0;
    end
    if (state_q == S_ST_MEM && !mem_rdy) ctrl.pc_write = 1'b0;
    if (state_q == S_BR && !bcond) ctrl.pc_write = 1'b0;
    if (state_q == S_ID && opcode == OP_ECALL && halt_req) ctrl.pc_write = 1'b0;
    if (reset) begin
      ctrl.pc_write     = 1'b0;
      ctrl.ir_write     = 1'b0;
      ctrl.aluout_write = 1'b0;
      ctrl.reg_write    = 1'b0;
      ctrl.mem_read     = 1'b0;
      ctrl.mem_write    = 1'b0;
      ctrl.illegal_op   = 1'b0;
    end
    instret_d = ctrl.pc_write ? instret_q + CNT_W'(1) : instret_q;
  end

  assign pc_write     = ctrl.pc_write;
  assign ir_write     = ctrl.ir_write;
  assign aluout_write = ctrl.aluout_write;
  assign reg_write    = ctrl.reg_write;
  assign mem_read     = ctrl.mem_read;
  assign mem_write    = ctrl.mem_write;
  assign iord         = ctrl.iord;
  assign mem_to_reg   = ctrl.mem_to_reg;
  assign pc_source    = ctrl.pc_source;
  assign alu_src_a    = ctrl.alu_src_a;
  assign alu_src_b    = ctrl.alu_src_b;
  assign alu_op       = ctrl.alu_op;
  assign illegal_op   = ctrl.illegal_op;
  assign is_halted    = (state_q == S_HALT);
  assign instret      = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-instruction cycle scripts derived from the ISA
// phase rules, with randomized waits, don't-care inputs and opcodes.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011,
                         OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_EC = 7'b1110011;
  localparam bit [1:0] ADD = 2'd0, BRN = 2'd1, FN = 2'd2;
  localparam bit [1:0] BREG = 2'd0, B4 = 2'd1, BIMM = 2'd2;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_JALR = 6,
                 C_EC = 7, C_ILL = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = '0;
  logic bcond = 1'b0, mem_ready = 1'b0, mem_ready0 = 1'b0, halt_req = 1'b0;

  logic pc_write, ir_write, aluout_write, reg_write, mem_read, mem_write, iord;
  logic mem_to_reg, pc_source, alu_src_a, is_halted, illegal_op;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] instret;

  logic o0_pc_write, o0_ir_write, o0_aluout_write, o0_reg_write, o0_mem_read, o0_mem_write;
  logic o0_iord, o0_mem_to_reg, o0_pc_source, o0_alu_src_a, o0_is_halted, o0_illegal_op;
  logic [1:0] o0_alu_src_b, o0_alu_op;
  logic [31:0] o0_instret;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_WAIT(1), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
    .halt_req(halt_req), .pc_write(pc_write), .ir_write(ir_write),
    .aluout_write(aluout_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .mem_to_reg(mem_to_reg), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .is_halted(is_halted), .illegal_op(illegal_op), .instret(instret));

  multicycle_control_fsm #(.MEM_WAIT(0), .CNT_W(32)) u_dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready0),
    .halt_req(halt_req), .pc_write(o0_pc_write), .ir_write(o0_ir_write),
    .aluout_write(o0_aluout_write), .reg_write(o0_reg_write), .mem_read(o0_mem_read),
    .mem_write(o0_mem_write), .iord(o0_iord), .mem_to_reg(o0_mem_to_reg),
    .pc_source(o0_pc_source), .alu_src_a(o0_alu_src_a), .alu_src_b(o0_alu_src_b),
    .alu_op(o0_alu_op), .is_halted(o0_is_halted), .illegal_op(o0_illegal_op),
    .instret(o0_instret));

  typedef struct {
    logic [7:0] en;
    logic [7:0] sel;
    logic [7:0] msk;
    logic mr, bc, hr, ret;
  } exp_t;

  exp_t q[$];
  logic [6:0] cur_opc;
  int exp_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit chk0 = 1'b0;
  string cur_test = "";

  wire [7:0] act_en  = {pc_write, ir_write, aluout_write, reg_write, mem_read, mem_write,
                        illegal_op, is_halted};
  wire [7:0] act_sel = {iord, mem_to_reg, pc_source, alu_src_a, alu_src_b, alu_op};
  wire [7:0] act0_en = {o0_pc_write, o0_ir_write, o0_aluout_write, o0_reg_write, o0_mem_read,
                        o0_mem_write, o0_illegal_op, o0_is_halted};
  wire [7:0] act0_sel = {o0_iord, o0_mem_to_reg, o0_pc_source, o0_alu_src_a, o0_alu_src_b,
                         o0_alu_op};

  // One expected cycle; selects only matter where the enable that uses them is set
  function automatic exp_t e(input bit pcw, irw, aow, rw, mrd, mwr, ill, hlt,
                             input bit io, m2r, psrc, alu, a, input bit [1:0] b, op,
                             input bit ret);
    exp_t t;
    t.en  = {pcw, irw, aow, rw, mrd, mwr, ill, hlt};
    t.sel = {io, m2r, psrc, a, b, op};
    t.msk = {mrd | mwr, rw, pcw, alu, {2{alu}}, {2{alu}}};
    t.mr  = 1'($urandom);
    t.bc  = 1'($urandom);
    t.hr  = 1'($urandom);
    t.ret = ret;
    return t;
  endfunction

  function automatic logic [6:0] opc_of(input int cls);
    logic [6:0] o;
    case (cls)
      C_R: o = OPC_R;   C_I: o = OPC_I;     C_LD: o = OPC_LD;    C_ST: o = OPC_ST;
      C_BR: o = OPC_BR; C_JAL: o = OPC_JAL; C_JALR: o = OPC_JALR; C_EC: o = OPC_EC;
      default: begin
        do o = 7'($urandom);
        while (o inside {OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL, OPC_JALR, OPC_EC});
      end
    endcase
    return o;
  endfunction

  task automatic build(input int cls, input logic [6:0] opc, input int wif, input int wmem,
                       input bit b, input bit h);
    exp_t t;
    cur_opc = opc;
    for (int k = 0; k < wif; k++) begin
      t = e(0,0,0,0,1,0,0,0, 0,0,0,0,0,BREG,ADD, 0); t.mr = 1'b0; q.push_back(t);
    end
    t = e(0,1,1,0,1,0,0,0, 0,0,0,1,1,B4,ADD, 0); t.mr = 1'b1; q.push_back(t);
    case (cls)
      C_BR:  t = e(0,0,1,0,0,0,0,0, 0,0,0,1,1,BIMM,ADD, 0);
      C_EC:  begin
        if (h) t = e(0,0,0,0,0,0,0,0, 0,0,0,0,0,BREG,ADD, 0);
        else   t = e(1,0,0,0,0,0,0,0, 0,0,0,1,1,B4,ADD, 1);
        t.hr = h;
      end
      C_ILL: t = e(1,0,0,0,0,0,1,0, 0,0,0,1,1,B4,ADD, 1);
      default: t = e(0,0,0,0,0,0,0,0, 0,0,0,0,0,BREG,ADD, 0);
    endcase
    q.push_back(t);
    case (cls)
      C_R, C_I: begin
        q.push_back(e(0,0,1,0,0,0,0,0, 0,0,0,1,0,(cls == C_R) ? BREG : BIMM,FN, 0));
        q.push_back(e(1,0,0,1,0,0,0,0, 0,0,0,1,1,B4,ADD, 1));
      end
      C_LD: begin
        q.push_back(e(0,0,1,0,0,0,0,0, 0,0,0,1,0,BIMM,ADD, 0));
        for (int k = 0; k < wmem; k++) begin
          t = e(0,0,0,0,1,0,0,0, 1,0,0,0,0,BREG,ADD, 0); t.mr = 1'b0; q.push_back(t);
        end
        t = e(0,0,0,0,1,0,0,0, 1,0,0,0,0,BREG,ADD, 0); t.mr = 1'b1; q.push_back(t);
        q.push_back(e(1,0,0,1,0,0,0,0, 0,1,0,1,1,B4,ADD, 1));
      end
      C_ST: begin
        q.push_back(e(0,0,1,0,0,0,0,0, 0,0,0,1,0,BIMM,ADD, 0));
        for (int k = 0; k < wmem; k++) begin
          t = e(0,0,0,0,0,1,0,0, 1,0,0,0,0,BREG,ADD, 0); t.mr = 1'b0; q.push_back(t);
        end
        t = e(1,0,0,0,0,1,0,0, 1,0,0,1,1,B4,ADD, 1); t.mr = 1'b1; q.push_back(t);
      end
      C_BR: begin
        if (b) t = e(1,0,0,0,0,0,0,0, 0,0,1,1,0,BREG,BRN, 1);
        else   t = e(0,0,0,0,0,0,0,0, 0,0,0,1,0,BREG,BRN, 0);
        t.bc = b; q.push_back(t);
        if (!b) q.push_back(e(1,0,0,0,0,0,0,0, 0,0,0,1,1,B4,ADD, 1));
      end
      C_JAL:  q.push_back(e(1,0,0,1,0,0,0,0, 0,0,0,1,1,BIMM,ADD, 1));
      C_JALR: q.push_back(e(1,0,0,1,0,0,0,0, 0,0,0,1,0,BIMM,ADD, 1));
      default: ;
    endcase
  endtask

  task automatic exec(input int max_cyc);
    exp_t t;
    int n = 0;
    while (q.size() > 0 && n < max_cyc) begin
      t = q.pop_front();
      opcode = cur_opc; mem_ready = t.mr; mem_ready0 = 1'($urandom);
      bcond = t.bc; halt_req = t.hr;
      @(negedge clk);
      n_checks++;
      if (act_en !== t.en) begin
        n_fail++;
        $display("FAIL %s enables cyc %0d: got %b required %b", cur_test, n, act_en, t.en);
      end
      n_checks++;
      if ((act_sel & t.msk) !== (t.sel & t.msk)) begin
        n_fail++;
        $display("FAIL %s selects cyc %0d: got %b required %b (mask %b)", cur_test, n,
                 act_sel, t.sel, t.msk);
      end
      n_checks++;
      if (instret !== 4'(exp_cnt)) begin
        n_fail++;
        $display("FAIL %s instret cyc %0d: got %0d required %0d", cur_test, n, instret,
                 exp_cnt % 16);
      end
      if (chk0) begin
        n_checks++;
        if (act0_en !== t.en || (act0_sel & t.msk) !== (t.sel & t.msk) ||
            o0_instret !== 32'(exp_cnt)) begin
          n_fail++;
          $display("FAIL %s nowait cyc %0d: got %b/%b/%0d required %b/%b/%0d", cur_test, n,
                   act0_en, act0_sel & t.msk, o0_instret, t.en, t.sel & t.msk, exp_cnt);
        end
      end
      @(posedge clk);
      if (t.ret) exp_cnt++;
      #1;
      n++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = 7'($urandom); bcond = 1'($urandom); mem_ready = 1'($urandom);
      mem_ready0 = 1'($urandom); halt_req = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (act_en[7:1] !== 7'd0 || act0_en[7:1] !== 7'd0) begin
        n_fail++;
        $display("FAIL %s reset enables: got %b / %b required 0", cur_test, act_en[7:1],
                 act0_en[7:1]);
      end
      if (i > 0) begin
        n_checks++;
        if (instret !== 4'd0 || o0_instret !== 32'd0 || is_halted !== 1'b0) begin
          n_fail++;
          $display("FAIL %s reset state: instret %0d/%0d halted %b required 0", cur_test,
                   instret, o0_instret, is_halted);
        end
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_add();
    cur_test = "add";
    build(C_R, OPC_R, 0, 0, 0, 0);
    exec(100);
    n_checks++;
    if (instret !== 4'd1) begin
      n_fail++; $display("FAIL add instret: got %0d required 1", instret);
    end
  endtask

  task automatic test_load_wait();
    cur_test = "lw_wait";
    build(C_LD, OPC_LD, 0, 2, 0, 0);
    exec(100);
    n_checks++;
    if (instret !== 4'd2) begin
      n_fail++; $display("FAIL lw_wait instret: got %0d required 2", instret);
    end
    cur_test = "sw_wait";
    build(C_ST, OPC_ST, 1, 2, 0, 0);
    exec(100);
  endtask

  task automatic test_branch();
    cur_test = "beq_taken";
    build(C_BR, OPC_BR, 0, 0, 1, 0);
    exec(100);
    cur_test = "beq_not_taken";
    build(C_BR, OPC_BR, 0, 0, 0, 0);
    exec(100);
  endtask

  task automatic test_ecall_illegal();
    cur_test = "illegal_zero";
    build(C_ILL, 7'b0000000, 0, 0, 0, 0);
    exec(100);
    cur_test = "ecall_no_halt";
    build(C_EC, OPC_EC, 0, 0, 0, 0);
    exec(100);
    cur_test = "jumps";
    build(C_JAL, OPC_JAL, 0, 0, 0, 0);
    exec(100);
    build(C_JALR, OPC_JALR, 1, 0, 0, 0);
    exec(100);
  endtask

  task automatic test_wrap();
    int cls;
    cur_test = "wrap";
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cls = (i % 3 == 0) ? C_EC : ((i % 3 == 1) ? C_ILL : C_JAL);
      build(cls, opc_of(cls), 0, 0, 0, 0);
      exec(100);
    end
    n_checks++;
    if (instret !== 4'd0 || exp_cnt != 16) begin
      n_fail++; $display("FAIL wrap instret: got %0d required 0 after 16", instret);
    end
  endtask

  task automatic test_reset_mid_load();
    cur_test = "reset_in_ld_mem";
    build(C_R, OPC_R, 0, 0, 0, 0);
    exec(100);
    build(C_LD, OPC_LD, 0, 3, 0, 0);
    exec(5);
    do_reset();
    cur_test = "after_abort";
    build(C_R, OPC_R, 0, 0, 0, 0);
    exec(100);
  endtask

  task automatic test_no_wait();
    int cls;
    cur_test = "no_wait";
    do_reset();
    chk0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cls = $urandom_range(0, 8);
      build(cls, opc_of(cls), 0, 0, 1'($urandom), 0);
      exec(100);
    end
    chk0 = 1'b0;
  endtask

  task automatic test_random();
    int cls;
    cur_test = "random";
    do_reset();
    for (int i = 0; i < 50; i++) begin
      cls = $urandom_range(0, 8);
      build(cls, opc_of(cls), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 0);
      exec(100);
    end
  endtask

  task automatic test_halt();
    logic [3:0] held;
    cur_test = "halt";
    build(C_R, OPC_R, 0, 0, 0, 0);
    exec(100);
    build(C_EC, OPC_EC, 1, 0, 0, 1);
    exec(100);
    held = 4'(exp_cnt);
    for (int i = 0; i < 100; i++) begin
      opcode = 7'($urandom); bcond = 1'($urandom); mem_ready = 1'($urandom);
      halt_req = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (act_en !== 8'b0000_0001 || instret !== held) begin
        n_fail++;
        $display("FAIL halt cyc %0d: enables %b instret %0d required 00000001 / %0d", i,
                 act_en, instret, held);
      end
      @(posedge clk);
      #1;
    end
    do_reset();
    cur_test = "after_halt";
    build(C_R, OPC_R, 0, 0, 0, 0);
    exec(100);
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_ecall_illegal();
    test_wrap();
    test_reset_mid_load();
    test_no_wait();
    test_random();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
